// File: rtl/spi_byte_master_pkg.sv
// spi_byte_master_pkg: FSM state type, bit-order constants and divider helper for spi_byte_master
package spi_byte_master_pkg;
  typedef enum logic [2:0] {IDLE, START, HIGH, LOW, HOLD, CHECK} spi_state_t;
  localparam logic SPI_MSB_FIRST = 1'b0;
  localparam logic SPI_LSB_FIRST = 1'b1;
  function automatic int half_period(input int clk_frec, input int scl_frec);
    return clk_frec / (2 * scl_frec);
  endfunction
endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: pulses o_tick on every HALF-th enabled clk; i_clr restarts the count at 0
module spi_half_tick #(
  parameter int HALF = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);
  localparam int W = HALF > 1 ? $clog2(HALF) : 1;
  logic [W-1:0] r_cnt;
  assign o_tick = i_en && (r_cnt == W'(HALF - 1));
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + W'(1);
  end
endmodule

// File: rtl/spi_byte_master.sv
// spi_byte_master: mode-0 SPI byte master with continuous transfers and selectable bit order.
// Define SPI_BYTE_MASTER_BUSY_EN to add the busy output (high while the FSM is not IDLE).
module spi_byte_master
  import spi_byte_master_pkg::*;
#(
  parameter int CLK_FREC = 100000000,
  parameter int SCL_FREC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_2_send,
  output logic [7:0] byte_received,
  output logic       new_byte,
  output logic       end_trans,
  input  logic       msb_lsb,
  input  logic       ena_spi,
  input  logic       miso,
  output logic       mosi,
  output logic       scl,
  output logic       cs
`ifdef SPI_BYTE_MASTER_BUSY_EN
  ,
  output logic       busy
`endif
);
  localparam int HALF = half_period(CLK_FREC, SCL_FREC);
  spi_state_t r_state, w_next;
  logic       w_tick, w_guard_tick, w_start;
  logic       r_guard_ok, r_lsb, r_scl, r_cs, r_mosi, r_new, r_end;
  logic [2:0] r_bit;
  logic [7:0] r_tx, r_rx, r_rx_byte, w_tx_sh;
  assign w_start       = (w_next == START) && (r_state != START);
  assign w_tx_sh       = (r_lsb == SPI_LSB_FIRST) ? {1'b0, r_tx[7:1]} : {r_tx[6:0], 1'b0};
  assign scl           = r_scl;
  assign cs            = r_cs;
  assign mosi          = r_mosi;
  assign new_byte      = r_new;
  assign end_trans     = r_end;
  assign byte_received = r_rx_byte;
`ifdef SPI_BYTE_MASTER_BUSY_EN
  assign busy = r_state != IDLE;
`endif
  spi_half_tick #(.HALF(HALF)) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_en   (r_state != IDLE),
    .o_tick (w_tick)
  );
  // keeps cs high for at least a half period between transfers
  spi_half_tick #(.HALF(HALF)) u_guard (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state != IDLE),
    .i_en   ((r_state == IDLE) && !r_guard_ok),
    .o_tick (w_guard_tick)
  );
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (ena_spi && r_guard_ok) ? START : IDLE;
      START:   w_next = w_tick ? HIGH : START;
      HIGH:    w_next = w_tick ? LOW : HIGH;
      LOW:     w_next = w_tick ? ((r_bit == 3'd7) ? HOLD : HIGH) : LOW;
      HOLD:    w_next = w_tick ? CHECK : HOLD;
      CHECK:   w_next = ena_spi ? START : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl      <= 1'b0;
      r_cs       <= 1'b1;
      r_mosi     <= 1'b0;
      r_new      <= 1'b0;
      r_end      <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_guard_ok <= 1'b1;
      r_lsb      <= 1'b0;
      r_bit      <= 3'd0;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
    end else begin
      r_scl      <= w_next == HIGH;
      r_cs       <= w_next == IDLE;
      r_new      <= (r_state == LOW) && (w_next == HOLD);
      r_end      <= (r_state == HOLD) && (w_next == CHECK);
      r_guard_ok <= (r_state == IDLE) && (r_guard_ok || w_guard_tick);
      if (w_start) begin
        r_tx   <= byte_2_send;
        r_lsb  <= msb_lsb;
        r_bit  <= 3'd0;
        r_mosi <= (msb_lsb == SPI_MSB_FIRST) ? byte_2_send[7] : byte_2_send[0];
      end
      if ((r_state != HIGH) && (w_next == HIGH))
        r_rx <= (r_lsb == SPI_LSB_FIRST) ? {miso, r_rx[7:1]} : {r_rx[6:0], miso};
      if ((r_state == LOW) && (w_next == HIGH)) r_bit <= r_bit + 3'd1;
      // the last bit stays on mosi through HOLD
      if ((r_state == HIGH) && (w_next == LOW) && (r_bit != 3'd7)) begin
        r_tx   <= w_tx_sh;
        r_mosi <= (r_lsb == SPI_LSB_FIRST) ? w_tx_sh[0] : w_tx_sh[7];
      end
      if ((r_state == LOW) && (w_next == HOLD)) r_rx_byte <= r_rx;
      if (w_next == IDLE) r_mosi <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: vector table plus scoreboard against a bit-level SPI slave model
module tb_spi_byte_master;
  import spi_byte_master_pkg::*;
  localparam int CLK_FREC = 100_000_000;
  localparam int SCL_FREC = 5_000_000;
  localparam int HALF = CLK_FREC / (2 * SCL_FREC);
  typedef struct {
    logic [7:0] tx;
    logic       lsb;
    logic       cont;
    logic [7:0] rx;
    logic [7:0] mosi_raw;
  } vec_t;
  typedef struct {
    logic [7:0] mosi_raw;
    logic [7:0] rx;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, ena_spi = 1'b0, msb_lsb = 1'b0, miso = 1'b0;
  logic [7:0] byte_2_send = 8'h00;
  logic [7:0] byte_received;
  logic new_byte, end_trans, mosi, scl, cs;
`ifdef SPI_BYTE_MASTER_BUSY_EN
  logic busy;
`endif
  always #5 clk = ~clk;
  spi_byte_master #(.CLK_FREC(CLK_FREC), .SCL_FREC(SCL_FREC)) dut (
    .clk           (clk),
    .rst           (rst),
    .byte_2_send   (byte_2_send),
    .byte_received (byte_received),
    .new_byte      (new_byte),
    .end_trans     (end_trans),
    .msb_lsb       (msb_lsb),
    .ena_spi       (ena_spi),
    .miso          (miso),
    .mosi          (mosi),
    .scl           (scl),
    .cs            (cs)
`ifdef SPI_BYTE_MASTER_BUSY_EN
    ,
    .busy          (busy)
`endif
  );
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = b[7-j];
    return r;
  endfunction
  // slave: sends src[] bytes first-bit-first, records mosi bits in time order into got[]
  logic [7:0] src [0:511];
  logic [7:0] got [0:511];
  int n_src = 0, n_got = 0, s_src = 0, s_bits = 0;
  bit s_loaded = 0;
  logic [7:0] s_out = 8'h00, s_in = 8'h00;
  logic p_scl = 1'b0, p_cs = 1'b1;
  always @(scl or cs or rst) begin
    if (rst === 1'b1) begin
      s_bits   = 0;
      s_loaded = 0;
    end else begin
      if (p_cs === 1'b1 && cs === 1'b0 && !s_loaded) begin
        s_out = (s_src < n_src) ? src[s_src] : 8'h00;
        s_src++;
        s_loaded = 1;
        miso = s_out[7];
      end
      if (p_scl === 1'b0 && scl === 1'b1 && cs === 1'b0) begin
        s_in = {s_in[6:0], mosi};
        s_bits++;
        if (s_bits == 8) begin
          got[n_got] = s_in;
          n_got++;
          s_bits = 0;
          s_loaded = 0;
          if (s_src < n_src) begin
            s_out = src[s_src];
            s_src++;
            s_loaded = 1;
            miso = s_out[7];
          end
        end
      end
      if (p_scl === 1'b1 && scl === 1'b0 && cs === 1'b0 && s_bits != 0) miso = s_out[7-s_bits];
    end
    p_scl = scl;
    p_cs  = cs;
  end
  int cyc = 0, n_nb = 0, n_et = 0, n_rise = 0, last_rise = 0, scl_per = 0, cs_run = 0, cs_hi_len = 0;
  logic scl_d = 1'b0, cs_d = 1'b1;
  always @(posedge clk) begin
    cyc++;
    if (new_byte === 1'b1) n_nb++;
    if (end_trans === 1'b1) n_et++;
    if (scl === 1'b1 && scl_d === 1'b0) begin
      n_rise++;
      scl_per = cyc - last_rise;
      last_rise = cyc;
    end
    if (cs === 1'b1) cs_run++;
    else begin
      if (cs_d === 1'b1) cs_hi_len = cs_run;
      cs_run = 0;
    end
    scl_d = scl;
    cs_d  = cs;
  end
  vec_t vecs[$];
  exp_t exp_q[$];
  int k = 0;
  function automatic vec_t mk(input logic [7:0] tx, input logic [7:0] rx, input logic lsb, input logic cont);
    vec_t v;
    v.tx = tx;
    v.rx = rx;
    v.lsb = lsb;
    v.cont = cont;
    v.mosi_raw = (lsb == SPI_LSB_FIRST) ? rev8(tx) : tx;
    return v;
  endfunction
  task automatic put_src(input vec_t v);
    src[n_src] = v.lsb ? rev8(v.rx) : v.rx;
    n_src++;
  endtask
  task automatic wait_ev(input bit et, input string name, output int n);
    n = 0;
    while (n < 40 * HALF) begin
      @(negedge clk);
      n++;
      if ((et ? end_trans : new_byte) === 1'b1) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout after %0d clks", name, n);
  endtask
  task automatic run(input int lo, input int hi);
    int n, prev_nb;
    bit first;
    exp_t e;
    vec_t v;
    prev_nb = 0;
    for (int i = lo; i <= hi; i++) begin
      v = vecs[i];
      first = (i == lo) || !vecs[i-1].cont;
      if (first) begin
        @(negedge clk);
        byte_2_send = v.tx;
        msb_lsb = v.lsb;
        put_src(v);
        if (v.cont) put_src(vecs[i+1]);
        exp_q.push_back('{v.mosi_raw, v.rx});
        ena_spi = 1'b1;
        if (!v.cont && v.lsb) begin
          repeat (3 * HALF) @(negedge clk);
          ena_spi = 1'b0;
        end
      end
      wait_ev(1'b0, "new_byte", n);
      e = exp_q.pop_front();
      chk($sformatf("byte_received[%0d]", i), byte_received, e.rx);
      chk($sformatf("mosi_bits[%0d]", i), got[k], e.mosi_raw);
      k++;
      chk($sformatf("scl_period[%0d]", i), scl_per, 2 * HALF);
      if (!first) chk($sformatf("byte_slot[%0d]", i), cyc - prev_nb, 18 * HALF + 1);
      if (first && i > 0) chk($sformatf("cs_gap[%0d]", i), cs_hi_len >= HALF, 1);
      prev_nb = cyc;
      if (v.cont) begin
        byte_2_send = vecs[i+1].tx;
        msb_lsb = vecs[i+1].lsb;
        if (vecs[i+1].cont) put_src(vecs[i+2]);
        exp_q.push_back('{vecs[i+1].mosi_raw, vecs[i+1].rx});
      end
      wait_ev(1'b1, "end_trans", n);
      chk($sformatf("nb_to_et[%0d]", i), n, HALF);
      if (!v.cont) ena_spi = 1'b0;
      @(negedge clk);
      chk($sformatf("cs_after[%0d]", i), cs, !v.cont);
    end
  endtask
  initial begin
    int r0, nb0, et0;
    for (int i = 0; i < 56; i++)
      vecs.push_back(mk(8'(i), (i == 0) ? 8'h01 : (i == 1) ? 8'h02 : 8'(i ^ 8'h5A), 1'b0, 1'b0));
    for (int i = 0; i < 50; i++) vecs.push_back(mk(8'(8'h38 + i), 8'(8'hC0 ^ i), 1'b0, i != 49));
    for (int r = 12; r <= 50; r++) vecs.push_back(mk(~8'(r), 8'(r), 1'b0, r != 50));
    for (int r = 34; r <= 122; r++) vecs.push_back(mk(8'(r ^ 8'h33), 8'(r), 1'b0, r != 122));
    vecs.push_back(mk(8'hA5, 8'h3C, 1'b1, 1'b0));
    vecs.push_back(mk(8'h01, 8'h80, 1'b1, 1'b0));
    vecs.push_back(mk(8'h3C, 8'h01, 1'b1, 1'b0));
    vecs.push_back(mk(8'h83, 8'h12, 1'b1, 1'b1));
    vecs.push_back(mk(8'h83, 8'h12, 1'b0, 1'b0));
    vecs.push_back(mk(8'h96, 8'h69, 1'b0, 1'b0));
    repeat (5) @(negedge clk);
    chk("rst_cs", cs, 1'b1);
    chk("rst_scl", scl, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_byte_received", byte_received, 8'h00);
    chk("rst_new_byte", new_byte, 1'b0);
    chk("rst_end_trans", end_trans, 1'b0);
    rst = 1'b0;
    run(0, vecs.size() - 2);
    @(negedge clk);
    byte_2_send = 8'h5A;
    msb_lsb = SPI_MSB_FIRST;
    src[n_src] = 8'hFF;
    n_src++;
    ena_spi = 1'b1;
    r0 = n_rise;
    for (int c = 0; c < 40 * HALF && n_rise - r0 < 3; c++) @(negedge clk);
    chk("abort_rises", n_rise - r0, 3);
    nb0 = n_nb;
    et0 = n_et;
    rst = 1'b1;
    ena_spi = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cs", cs, 1'b1);
    chk("abort_scl", scl, 1'b0);
    chk("abort_mosi", mosi, 1'b0);
    chk("abort_byte_received", byte_received, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20 * HALF) @(negedge clk);
    chk("abort_new_byte_cnt", n_nb, nb0);
    chk("abort_end_trans_cnt", n_et, et0);
    chk("abort_byte_received_hold", byte_received, 8'h00);
    run(vecs.size() - 1, vecs.size() - 1);
    repeat (4) @(negedge clk);
    chk("total_new_byte", n_nb, vecs.size());
    chk("total_end_trans", n_et, vecs.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
